// File: rtl/mul_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier.
//   state_e     : control FSM state
//   digit_e     : recoded Booth digit in {0, +1, +2, -1, -2}
//   digit_count : number of radix-4 digits (and run cycles) for a given operand width
package mul_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef enum logic [2:0] {
        DigZero,
        DigPos1,
        DigPos2,
        DigNeg1,
        DigNeg2
    } digit_e;

    // Operands are extended by two bits so the top digit also covers the sign/zero extension.
    function automatic int unsigned digit_count(input int unsigned width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: maps the multiplier bit triplet {q[2i+1], q[2i], q[2i-1]} to a digit.
// Ports:
//   triplet_i : 3-bit multiplier window
//   digit_o   : recoded digit
module booth_r4_recode
    import mul_pkg::*;
(
    input  logic [2:0] triplet_i,
    output digit_e     digit_o
);

    always_comb begin
        digit_o = DigZero;
        unique case (triplet_i)
            3'b001, 3'b010: digit_o = DigPos1;
            3'b011:         digit_o = DigPos2;
            3'b100:         digit_o = DigNeg2;
            3'b101, 3'b110: digit_o = DigNeg1;
            default:        digit_o = DigZero;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Sequential radix-4 Booth multiplier, one recoded digit per clock.
// Ports:
//   clock        : rising-edge clock
//   clear        : synchronous active-high reset
//   start        : request, honoured only while busy is low
//   signed_mode  : 1 = two's-complement operands, 0 = unsigned (latched with operands)
//   multiplicand : operand M
//   multiplier   : operand Q
//   busy         : multiplication in progress
//   done         : one-cycle pulse when product is updated
//   product      : M*Q mod 2^(2*WIDTH), held until the next completion
module booth_r4_seq_mul
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned N    = digit_count(WIDTH);
    localparam int unsigned CntW = $clog2(N);
    localparam int unsigned XW   = WIDTH + 2;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [XW-1:0]        m_q, m_d;
    logic [XW-1:0]        q_q, q_d;
    logic                 qm1_q, qm1_d;
    // Accumulator {hi, lo}: hi takes the digit add, lo collects bits shifted out of hi.
    logic [XW-1:0]        hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    digit_e               digit;
    logic [XW-1:0]        mag;
    logic                 neg;
    logic [XW-1:0]        sum;

    booth_r4_recode u_recode (
        .triplet_i ({q_q[1:0], qm1_q}),
        .digit_o   (digit)
    );

    // Single add/sub: magnitude selected by the digit, negation as invert plus carry-in.
    // hi + d*M always fits XW signed bits, so modular XW-bit arithmetic is exact.
    always_comb begin
        mag = '0;
        neg = 1'b0;
        unique case (digit)
            DigPos1: mag = m_q;
            DigPos2: mag = {m_q[XW-2:0], 1'b0};
            DigNeg1: begin mag = m_q;                     neg = 1'b1; end
            DigNeg2: begin mag = {m_q[XW-2:0], 1'b0};     neg = 1'b1; end
            default: mag = '0;
        endcase
        sum = hi_q + (mag ^ {XW{neg}}) + XW'(neg);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        product_d = product_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    m_d     = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                          : {2'b00, multiplicand};
                    q_d     = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                                          : {2'b00, multiplier};
                    qm1_d   = 1'b0;
                    hi_d    = '0;
                    lo_d    = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                // Arithmetic shift of the accumulator by one radix-4 digit.
                hi_d  = {{2{sum[XW-1]}}, sum[XW-1:2]};
                lo_d  = {sum[1:0], lo_q[WIDTH-1:2]};
                q_d   = {2'b00, q_q[XW-1:2]};
                qm1_d = q_q[1];
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    // After N-1 shifts lo holds the low WIDTH bits; the last sum is unshifted.
                    product_d = {sum[WIDTH-1:0], lo_q};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign product = product_q;

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Self-checking bench: recoder truth table, WIDTH=32 directed table, handshake and clear
// sequences, random WIDTH=32 ops and WIDTH=8 corner/random ops against an arithmetic model.
module tb_booth_r4_seq_mul;
    import mul_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear;
    logic        start32, sm32, busy32, done32;
    logic [31:0] m32, q32;
    logic [63:0] prod32;
    logic        start8, sm8, busy8, done8;
    logic [7:0]  m8, q8;
    logic [15:0] prod8;
    logic [2:0]  trip;
    digit_e      dig;

    int nvec = 0;
    int nmis = 0;

    booth_r4_seq_mul #(.WIDTH(32)) dut32 (
        .clock(clock), .clear(clear), .start(start32), .signed_mode(sm32),
        .multiplicand(m32), .multiplier(q32), .busy(busy32), .done(done32), .product(prod32)
    );

    booth_r4_seq_mul #(.WIDTH(8)) dut8 (
        .clock(clock), .clear(clear), .start(start8), .signed_mode(sm8),
        .multiplicand(m8), .multiplier(q8), .busy(busy8), .done(done8), .product(prod8)
    );

    booth_r4_recode u_rec (
        .triplet_i(trip),
        .digit_o  (dig)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] model32(input logic sm, input logic [31:0] m,
                                            input logic [31:0] q);
        logic [63:0] a, b;
        a = sm ? {{32{m[31]}}, m} : {32'd0, m};
        b = sm ? {{32{q[31]}}, q} : {32'd0, q};
        return a * b;
    endfunction

    function automatic logic [15:0] model8(input logic sm, input logic [7:0] m,
                                           input logic [7:0] q);
        logic [15:0] a, b;
        a = sm ? {{8{m[7]}}, m} : {8'd0, m};
        b = sm ? {{8{q[7]}}, q} : {8'd0, q};
        return a * b;
    endfunction

    task automatic mul32(input logic sm, input logic [31:0] m, input logic [31:0] q,
                         output logic [63:0] p, output int lat);
        @(negedge clock);
        start32 = 1'b1; sm32 = sm; m32 = m; q32 = q;
        @(posedge clock);
        #1 start32 = 1'b0;
        lat = 0;
        p   = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (done32) begin
                lat = k;
                p   = prod32;
                break;
            end
        end
    endtask

    task automatic run32(input string name, input logic sm, input logic [31:0] m,
                         input logic [31:0] q, input logic [63:0] exp);
        logic [63:0] p;
        int          lat;
        mul32(sm, m, q, p, lat);
        chk({name, " product"}, p, exp);
        chk({name, " latency"}, 64'(lat), 64'd17);
        @(posedge clock);
        #1 chk({name, " done pulse width"}, 64'(done32), 64'd0);
    endtask

    task automatic run8(input logic sm, input logic [7:0] m, input logic [7:0] q);
        int lat;
        logic [15:0] p;
        @(negedge clock);
        start8 = 1'b1; sm8 = sm; m8 = m; q8 = q;
        @(posedge clock);
        #1 start8 = 1'b0;
        lat = 0;
        p   = 'x;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            #1;
            if (done8) begin
                lat = k;
                p   = prod8;
                break;
            end
        end
        chk($sformatf("w8 sm=%0b %h*%h", sm, m, q), 64'(p), 64'(model8(sm, m, q)));
        chk("w8 latency", 64'(lat), 64'd5);
    endtask

    typedef struct {
        logic        sm;
        logic [31:0] m;
        logic [31:0] q;
        logic [63:0] p;
    } vec_t;

    vec_t   tbl[7];
    digit_e exp_dig[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p, first_exp, second_exp;
        logic [31:0] a2, b2;
        logic        s2;
        int          lat, ndone;
        logic [7:0]  corner[6];

        tbl[0] = '{1'b1, 32'd7,         32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        tbl[1] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        tbl[2] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
        tbl[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        tbl[4] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        tbl[5] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000};
        tbl[6] = '{1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 64'h7FFF_FFFF_8000_0000};
        exp_dig = '{DigZero, DigPos1, DigPos1, DigPos2, DigNeg2, DigNeg1, DigNeg1, DigZero};
        corner  = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55};

        clear = 1'b1;
        start32 = 1'b0; sm32 = 1'b0; m32 = '0; q32 = '0;
        start8  = 1'b0; sm8  = 1'b0; m8  = '0; q8  = '0;
        trip = '0;

        // Recoder truth table
        for (int i = 0; i < 8; i++) begin
            trip = 3'(i);
            #1 chk($sformatf("recode %03b", trip), 64'(dig), 64'(exp_dig[i]));
        end

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("reset busy", 64'(busy32), 64'd0);
        chk("reset done", 64'(done32), 64'd0);
        chk("reset product", prod32, 64'd0);
        chk("reset busy w8", 64'(busy8), 64'd0);
        @(negedge clock) clear = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++)
            run32($sformatf("table[%0d]", i), tbl[i].sm, tbl[i].m, tbl[i].q, tbl[i].p);

        // Start held high with operands changing during RUN, then back-to-back start
        first_exp = model32(1'b1, 32'd7, 32'hFFFF_FFFD);
        @(negedge clock);
        start32 = 1'b1; sm32 = 1'b1; m32 = 32'd7; q32 = 32'hFFFF_FFFD;
        @(posedge clock);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            m32 = $urandom; q32 = $urandom; sm32 = 1'($urandom);
            @(posedge clock);
            #1;
            if (k == 8) begin
                chk("busy during run", 64'(busy32), 64'd1);
                chk("product held during run", prod32, tbl[6].p);
            end
            if (done32) begin
                lat = k;
                break;
            end
        end
        chk("held-start latency", 64'(lat), 64'd17);
        chk("held-start product", prod32, first_exp);
        @(negedge clock);
        a2 = $urandom; b2 = $urandom; s2 = 1'($urandom);
        m32 = a2; q32 = b2; sm32 = s2;
        second_exp = model32(s2, a2, b2);
        @(posedge clock);
        #1 start32 = 1'b0;
        chk("back-to-back busy", 64'(busy32), 64'd1);
        chk("back-to-back done low", 64'(done32), 64'd0);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (k == 10) chk("old product held", prod32, first_exp);
            if (done32) begin
                lat = k;
                break;
            end
        end
        chk("back-to-back latency", 64'(lat), 64'd17);
        chk("back-to-back product", prod32, second_exp);

        // Clear in the middle of a run
        @(negedge clock);
        start32 = 1'b1; sm32 = 1'b0; m32 = 32'h1234_5678; q32 = 32'h9ABC_DEF0;
        @(posedge clock);
        #1 start32 = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock) clear = 1'b1;
        @(posedge clock);
        #1;
        chk("clear busy", 64'(busy32), 64'd0);
        chk("clear done", 64'(done32), 64'd0);
        chk("clear product", prod32, 64'd0);
        @(negedge clock) clear = 1'b0;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clock);
            #1 if (done32 || busy32) ndone++;
        end
        chk("no activity after clear", 64'(ndone), 64'd0);
        run32("after clear", 1'b1, 32'hFFFF_FFF0, 32'd100, model32(1'b1, 32'hFFFF_FFF0, 32'd100));

        // Random WIDTH=32
        for (int i = 0; i < 150; i++) begin
            a2 = $urandom; b2 = $urandom; s2 = 1'($urandom);
            run32($sformatf("rand sm=%0b %h*%h", s2, a2, b2), s2, a2, b2, model32(s2, a2, b2));
        end

        // WIDTH=8 corners in both modes, then random pairs
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < 6; j++)
                    run8(1'(s), corner[i], corner[j]);
        for (int i = 0; i < 1200; i++)
            run8(1'($urandom), 8'($urandom), 8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
